// File: rtl/arm_word_rx_if.sv
// ARM PIO handshake plus downstream valid/ready stream, bundled for arm_word_rx.
interface arm_word_rx_if;
  logic        arm_val;
  logic        arm_ack;
  logic [31:0] arm_data;
  logic        fpga_ack;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] out_data;
  logic        out_first;
  logic        out_last;

  // Receiver side: consumes the ARM handshake, sources the stream.
  modport slave (
    input  arm_val, arm_ack, arm_data, out_ready,
    output fpga_ack, out_valid, out_data, out_first, out_last
  );

  // ARM / downstream side.
  modport master (
    output arm_val, arm_ack, arm_data, out_ready,
    input  fpga_ack, out_valid, out_data, out_first, out_last
  );
endinterface

// File: rtl/arm_word_rx.sv
// ARM->FPGA word receiver: four-phase PIO handshake, FWFT FIFO, packet framing.
module arm_word_rx #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  arm_word_rx_if.slave             bus,
  output logic [$clog2(DEPTH):0]   o_fifo_level,
  output logic [7:0]               o_word_count,
  output logic                     o_overrun_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLvl = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWaitRel, StWaitEnd} state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic [32:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_in_packet;
  logic [7:0]    r_word_count;
  logic          r_overrun_err;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_first;
  logic [32:0]   w_head;
  logic [31:0]   w_count_inc;

  assign w_full      = (r_level == FullLvl);
  assign w_empty     = (r_level == '0);
  // One capture per handshake: only from IDLE, and never while the FIFO is full.
  assign w_push      = (r_state == StIdle) && bus.arm_val && !bus.arm_ack && !w_full;
  assign w_pop       = !w_empty && bus.out_ready;
  assign w_first     = !r_in_packet;
  assign w_count_inc = 32'(r_word_count) + 32'd1;
  assign w_head      = r_mem[r_rd_ptr];

  // Handshake state register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // Handshake next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:    if (w_push) w_state_next = StWaitRel;
      StWaitRel: if (!bus.arm_val && bus.arm_ack) w_state_next = StWaitEnd;
      StWaitEnd: if (!bus.arm_ack) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // fpga_ack is a pure state decode, so it rises with the push edge.
  always_comb begin
    bus.fpga_ack = (r_state == StWaitRel);
  end

  // FIFO storage; contents need no reset since level gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_first, bus.arm_data};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Packet framing, word counting and sticky overrun detection.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_in_packet   <= 1'b0;
      r_word_count  <= '0;
      r_overrun_err <= 1'b0;
    end else if (w_push) begin
      r_in_packet <= !bus.arm_data[31];
      if (w_first) begin
        r_word_count <= 8'd1;
      end else begin
        if (r_word_count != 8'hFF) r_word_count <= r_word_count + 8'd1;
        if (w_count_inc > MAX_WORDS) r_overrun_err <= 1'b1;
      end
    end
  end

  // First-word-fall-through stream outputs, forced to zero when empty.
  always_comb begin
    bus.out_valid = !w_empty;
    bus.out_first = !w_empty && w_head[32];
    bus.out_last  = !w_empty && w_head[31];
    bus.out_data  = w_empty ? '0 : w_head[30:0];
  end

  assign o_fifo_level  = r_level;
  assign o_word_count  = r_word_count;
  assign o_overrun_err = r_overrun_err;

endmodule
